seq_detect_moore_param: RTL
===========================

# seq_detect_moore_param

Parametrised Moore-type serial pattern detector for a bit-serial input stream. It generalises the fixed 6-bit detector to a configurable length and a runtime-loadable pattern. It adds an overlap/non-overlap mode, an input qualifier and a saturating match counter. It sits on serial data paths (framing, sync-word and marker detection) and drives a registered, state-decoded match flag.

## Interface
- LEN, 6: pattern length in bits, legal range 2..16.
- DEFAULT_PAT, 6'b101101: pattern loaded at reset, LEN bits wide. The MSB is the first bit received.
- CNT_W, 8: match counter width, minimum 1.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- x  in  1  serial data bit.
- x_valid  in  1  x is consumed only in cycles where this is high.
- overlap  in  1  1 = overlapping matches allowed; 0 = detector restarts after a match.
- load_pat  in  1  loads pat_in into the pattern register.
- pat_in  in  LEN  new pattern, MSB first.
- cnt_clr  in  1  synchronous clear of match_cnt.
- y  out  1  match flag, Moore: high iff state == LEN.
- match_cnt  out  CNT_W  saturating count of matches.
- state  out  clog2(LEN+1)  current matched-prefix length, for debug.

## Operation
- **State k (0..LEN):** length of the longest pattern prefix that is a suffix of the consumed history. Prefix j means pat[LEN-1 -: j]. State LEN is the match state.
- **Consumed bit, state k < LEN:** if x equals pat[LEN-1-k], go to k+1. Otherwise go to the largest j ≤ k such that the last j bits of (prefix_k followed by x) equal prefix_j. Use 0 if no such j exists.
- **Consumed bit, state LEN, overlap=1:** same rule applied to the full pattern followed by x, with j ≤ LEN. For the default pattern this gives: 0 → 2, 1 → 4.
- **Consumed bit, state LEN, overlap=0:** history is discarded. Go to 1 if x == pat[LEN-1], else 0.
- **Transition logic:** computed combinationally from the pattern register, so it must work for any loaded pattern. Loops over the LEN+1 candidate prefix lengths are acceptable.
- **x_valid=0:** state, y and match_cnt hold.
- **overlap:** sampled every cycle. It only affects transitions out of state LEN.
- **load_pat=1:** pattern register takes pat_in and state is forced to 0 on the next edge. match_cnt is unchanged. If x_valid is also high that cycle, the bit is discarded (load wins).
- **match_cnt:** increments by 1 on every consumed bit whose next state is LEN, including LEN → LEN. It saturates at 2^CNT_W-1. If cnt_clr coincides with an increment, the counter goes to 0 (clear wins).
- **y:** decoded from the registered state only. There is no combinational path from x.

## Timing
- Reset values: state=0, y=0, match_cnt=0, pattern register=DEFAULT_PAT.
- Reset is asynchronous: asserting rst mid-sequence drops y and state to 0 immediately and clears match_cnt. Operation resumes on the first rising edge after deassertion.
- Latency: y rises on the clock edge that consumes the last pattern bit and is visible in the following cycle. match_cnt updates on the same edge.
- y stays high until the next consumed bit or load_pat moves the state away from LEN. With x_valid low, y can therefore persist for many cycles.
- Back-to-back matches in overlap mode, e.g. when the pattern is a repeated bit, keep y high continuously, and match_cnt counts each one.

## Test plan
- **Overlap match:** defaults, overlap=1, x_valid=1, x = 1,0,1,1,0,1,1,0,1. Required: y high after bit 6 and after bit 9, low in between; state after bit 7 = 4; match_cnt=2.
- **Non-overlap:** same stream with overlap=0. Required: y high only after bit 6; state after bits 7..9 = 1,2,3; match_cnt=1.
- **Valid gaps:** bits of 101101 with x_valid low for 3 cycles between each bit. Required: same state sequence; y rises after the 6th valid bit and holds through the following idle cycles.
- **Pattern load:** load_pat with pat_in=6'b111000 while x_valid=1 (bit discarded), then x = 1,1,1,1,0,0,0. Required: state sequence 1,2,3,3,4,5,6; y high after bit 7; match_cnt increments by 1.
- **Counter:** CNT_W=2, five matches; then cnt_clr asserted in the same cycle as a sixth match. Required: match_cnt = 3 after five matches (saturated), then 0.
- **Reset mid-operation:** assert rst asynchronously while state=6 and y=1. Required: y, state and match_cnt go to 0 before the next clock edge; the pattern reverts to DEFAULT_PAT even after an earlier load.

Source files
------------

// File: rtl/seq_detect_moore_param.sv
// ---------------------------------------------------------------------------
// seq_detect_moore_param
// Parametrised Moore serial pattern detector with a runtime-loadable pattern,
// overlap / non-overlap restart, input qualifier and saturating match counter.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   x          serial data bit
//   x_valid    x is consumed only when high
//   overlap    1 = overlapping matches, 0 = restart after a match
//   load_pat   load pat_in into the pattern register, force state to 0
//   pat_in     new pattern, MSB is the first bit received
//   cnt_clr    synchronous clear of match_cnt (wins over an increment)
//   y          registered match flag, high iff state == LEN
//   match_cnt  saturating count of matches
//   state      matched-prefix length (debug)
// ---------------------------------------------------------------------------
module seq_detect_moore_param #(
  parameter int unsigned    LEN         = 6,
  parameter logic [LEN-1:0] DEFAULT_PAT = 6'b101101,
  parameter int unsigned    CNT_W       = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       x,
  input  logic                       x_valid,
  input  logic                       overlap,
  input  logic                       load_pat,
  input  logic [LEN-1:0]             pat_in,
  input  logic                       cnt_clr,
  output logic                       y,
  output logic [CNT_W-1:0]           match_cnt,
  output logic [$clog2(LEN+1)-1:0]   state
);

  localparam int unsigned SW = $clog2(LEN + 1);
  // History vector holds up to LEN pattern bits plus the incoming bit.
  localparam int unsigned HW = LEN + 1;
  localparam logic [SW-1:0] MATCH_ST = SW'(LEN);

  logic [LEN-1:0] pat_q;
  logic [SW-1:0]  next_st;
  logic [HW-1:0]  pat_ext;
  logic [HW-1:0]  hist;
  logic [HW-1:0]  mask;
  logic [HW-1:0]  pref;
  logic           consume;
  logic           hit;

  // Next matched-prefix length. The history is prefix_k followed by x; the
  // next state is the longest prefix j (j <= k+1, j <= LEN) that equals the
  // last j history bits. Scanning j upward leaves the largest match.
  always_comb begin
    next_st = '0;
    pat_ext = HW'(pat_q);
    hist    = '0;
    mask    = '0;
    pref    = '0;
    if (state == MATCH_ST && !overlap) begin
      // History discarded: only the new bit can start a fresh prefix.
      next_st = (x == pat_q[LEN-1]) ? SW'(1) : '0;
    end else begin
      hist = ((pat_ext >> (LEN - int'(state))) << 1) | HW'(x);
      for (int j = 1; j <= int'(LEN); j++) begin
        mask = (HW'(1) << j) - HW'(1);
        pref = pat_ext >> (int'(LEN) - j);
        if ((j <= int'(state) + 1) && ((hist & mask) == pref)) begin
          next_st = SW'(j);
        end
      end
    end
  end

  // A load in the same cycle discards the data bit.
  assign consume = x_valid & ~load_pat;
  assign hit     = consume & (next_st == MATCH_ST);

  // Pattern, state, match flag and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q     <= DEFAULT_PAT;
      state     <= '0;
      y         <= 1'b0;
      match_cnt <= '0;
    end else begin
      if (load_pat) begin
        pat_q <= pat_in;
        state <= '0;
        y     <= 1'b0;
      end else if (x_valid) begin
        state <= next_st;
        y     <= (next_st == MATCH_ST);
      end

      if (cnt_clr) begin
        match_cnt <= '0;
      end else if (hit && (match_cnt != {CNT_W{1'b1}})) begin
        match_cnt <= match_cnt + CNT_W'(1);
      end
    end
  end

endmodule
